// File: rtl/can_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// can_rx_frame_ctrl
//
// Receive-side frame sequencer for standard-format (11-bit ID) CAN frames.
// It qualifies bus idle, detects the SOF falling edge and enables the bit
// sampler. It then destuffs the sampler's bit strobes and walks the frame
// fields from SOF through the last CRC bit. The destuffed stream, header
// fields and status pulses are published to the downstream CRC and
// frame-assembly logic.
//
// Ports:
//   clk          system clock, the only clock
//   rst_n        synchronous active-low reset
//   din          rx line, already synchronized to clk (1 = recessive)
//   sample_bit   bit value from the sampler
//   sample_valid one-cycle strobe from the sampler
//   sample_en    sampler enable, high from SOF until the last CRC bit
//   bit_dout     destuffed frame bit (SOF excluded)
//   bit_dvalid   one-cycle strobe for bit_dout
//   field        current field: 0 idle, 1 arb, 2 ctrl, 3 data, 4 crc
//   id           received identifier
//   rtr          received RTR bit
//   dlc          received DLC
//   hdr_valid    one-cycle pulse when id/rtr/dlc are complete
//   frame_done   one-cycle pulse after the last CRC bit
//   stuff_err    one-cycle pulse on a stuff violation
//   form_err     one-cycle pulse on IDE=1 (extended frames unsupported)
// ---------------------------------------------------------------------------
module can_rx_frame_ctrl #(
   parameter int clk_speed_MHz      = 100,
   parameter int can_bit_rate_Kbits = 1000,
   parameter int idle_bits          = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        din,
   input  logic        sample_bit,
   input  logic        sample_valid,
   output logic        sample_en,
   output logic        bit_dout,
   output logic        bit_dvalid,
   output logic [2:0]  field,
   output logic [10:0] id,
   output logic        rtr,
   output logic [3:0]  dlc,
   output logic        hdr_valid,
   output logic        frame_done,
   output logic        stuff_err,
   output logic        form_err
);

   localparam int CLKS_PER_BIT = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
   localparam int IDLE_MAX     = idle_bits * CLKS_PER_BIT;
   localparam int IDLE_W       = $clog2(IDLE_MAX + 1);

   typedef enum logic [2:0] {
      S_WAIT_IDLE,
      S_IDLE,
      S_SOF,
      S_ARB,
      S_CTRL,
      S_DATA,
      S_CRC
   } state_t;

   state_t            state, state_nxt;
   logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
   logic              din_d;
   logic [6:0]        bit_cnt, bit_cnt_nxt;
   logic [2:0]        run, run_nxt;
   logic              last, last_nxt;

   logic        sample_en_nxt;
   logic        bit_dout_nxt;
   logic        bit_dvalid_nxt;
   logic [2:0]  field_nxt;
   logic [10:0] id_nxt;
   logic        rtr_nxt;
   logic [3:0]  dlc_nxt;
   logic        hdr_valid_nxt;
   logic        frame_done_nxt;
   logic        stuff_err_nxt;
   logic        form_err_nxt;

   // DLC values above 8 still carry only 8 bytes, so the data field length
   // saturates at 64 bits.
   logic [3:0] dlc_eff;
   logic [6:0] data_len;
   assign dlc_eff  = dlc[3] ? 4'd8 : dlc;
   assign data_len = {dlc_eff, 3'b000};

   // State and output registers. Reset wins over everything, including a
   // frame in progress, and returns the block to idle qualification.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_WAIT_IDLE;
         idle_cnt   <= '0;
         din_d      <= 1'b1;
         bit_cnt    <= '0;
         run        <= '0;
         last       <= 1'b0;
         sample_en  <= 1'b0;
         bit_dout   <= 1'b0;
         bit_dvalid <= 1'b0;
         field      <= 3'd0;
         id         <= '0;
         rtr        <= 1'b0;
         dlc        <= '0;
         hdr_valid  <= 1'b0;
         frame_done <= 1'b0;
         stuff_err  <= 1'b0;
         form_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         idle_cnt   <= idle_cnt_nxt;
         din_d      <= din;
         bit_cnt    <= bit_cnt_nxt;
         run        <= run_nxt;
         last       <= last_nxt;
         sample_en  <= sample_en_nxt;
         bit_dout   <= bit_dout_nxt;
         bit_dvalid <= bit_dvalid_nxt;
         field      <= field_nxt;
         id         <= id_nxt;
         rtr        <= rtr_nxt;
         dlc        <= dlc_nxt;
         hdr_valid  <= hdr_valid_nxt;
         frame_done <= frame_done_nxt;
         stuff_err  <= stuff_err_nxt;
         form_err   <= form_err_nxt;
      end
   end

   // Next-state and next-output logic. Every output is computed here one
   // cycle ahead so that it leaves the block straight from a flop.
   always_comb begin
      state_nxt      = state;
      idle_cnt_nxt   = idle_cnt;
      bit_cnt_nxt    = bit_cnt;
      run_nxt        = run;
      last_nxt       = last;
      sample_en_nxt  = sample_en;
      bit_dout_nxt   = bit_dout;
      bit_dvalid_nxt = 1'b0;
      id_nxt         = id;
      rtr_nxt        = rtr;
      dlc_nxt        = dlc;
      hdr_valid_nxt  = 1'b0;
      frame_done_nxt = 1'b0;
      stuff_err_nxt  = 1'b0;
      form_err_nxt   = 1'b0;

      unique case (state)
         S_WAIT_IDLE: begin
            sample_en_nxt = 1'b0;
            if (din) begin
               if (idle_cnt == IDLE_W'(IDLE_MAX - 1)) begin
                  state_nxt    = S_IDLE;
                  idle_cnt_nxt = '0;
               end else begin
                  idle_cnt_nxt = idle_cnt + IDLE_W'(1);
               end
            end else begin
               idle_cnt_nxt = '0;
            end
         end

         S_IDLE: begin
            if (din_d && !din) begin
               state_nxt     = S_SOF;
               sample_en_nxt = 1'b1;
            end
         end

         // A recessive first sample means the edge was a glitch; fall back
         // to IDLE without re-qualifying the bus.
         S_SOF: begin
            if (sample_valid) begin
               if (!sample_bit) begin
                  state_nxt   = S_ARB;
                  last_nxt    = 1'b0;
                  run_nxt     = 3'd1;
                  bit_cnt_nxt = '0;
               end else begin
                  state_nxt     = S_IDLE;
                  sample_en_nxt = 1'b0;
               end
            end
         end

         // After five equal bits the next one is a stuff bit: it must be
         // the opposite level, is dropped, and starts a new run.
         S_ARB, S_CTRL, S_DATA, S_CRC: begin
            if (sample_valid) begin
               if (run == 3'd5) begin
                  if (sample_bit != last) begin
                     run_nxt  = 3'd1;
                     last_nxt = sample_bit;
                  end else begin
                     stuff_err_nxt = 1'b1;
                     sample_en_nxt = 1'b0;
                     state_nxt     = S_WAIT_IDLE;
                     idle_cnt_nxt  = '0;
                  end
               end else begin
                  if (sample_bit == last) begin
                     run_nxt = run + 3'd1;
                  end else begin
                     run_nxt  = 3'd1;
                     last_nxt = sample_bit;
                  end
                  bit_dout_nxt   = sample_bit;
                  bit_dvalid_nxt = 1'b1;
                  bit_cnt_nxt    = bit_cnt + 7'd1;

                  unique case (state)
                     S_ARB: begin
                        if (bit_cnt < 7'd11) begin
                           id_nxt = {id[9:0], sample_bit};
                        end else begin
                           rtr_nxt     = sample_bit;
                           state_nxt   = S_CTRL;
                           bit_cnt_nxt = '0;
                        end
                     end

                     // Bit 0 is IDE, bit 1 is r0, bits 2..5 are the DLC.
                     S_CTRL: begin
                        if (bit_cnt == 7'd0 && sample_bit) begin
                           form_err_nxt   = 1'b1;
                           bit_dvalid_nxt = 1'b0;
                           sample_en_nxt  = 1'b0;
                           state_nxt      = S_WAIT_IDLE;
                           idle_cnt_nxt   = '0;
                        end else begin
                           if (bit_cnt >= 7'd2) begin
                              dlc_nxt = {dlc[2:0], sample_bit};
                           end
                           if (bit_cnt == 7'd5) begin
                              hdr_valid_nxt = 1'b1;
                              bit_cnt_nxt   = '0;
                              if (rtr || dlc_nxt == 4'd0) begin
                                 state_nxt = S_CRC;
                              end else begin
                                 state_nxt = S_DATA;
                              end
                           end
                        end
                     end

                     S_DATA: begin
                        if (bit_cnt == data_len - 7'd1) begin
                           state_nxt   = S_CRC;
                           bit_cnt_nxt = '0;
                        end
                     end

                     S_CRC: begin
                        if (bit_cnt == 7'd14) begin
                           frame_done_nxt = 1'b1;
                           sample_en_nxt  = 1'b0;
                           state_nxt      = S_WAIT_IDLE;
                           idle_cnt_nxt   = '0;
                           bit_cnt_nxt    = '0;
                        end
                     end

                     default: ;
                  endcase
               end
            end
         end

         default: begin
            state_nxt = S_WAIT_IDLE;
         end
      endcase

      // The field code follows the state the FSM is about to enter.
      unique case (state_nxt)
         S_ARB:   field_nxt = 3'd1;
         S_CTRL:  field_nxt = 3'd2;
         S_DATA:  field_nxt = 3'd3;
         S_CRC:   field_nxt = 3'd4;
         default: field_nxt = 3'd0;
      endcase
   end

endmodule

// File: tb/tb_can_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_can_rx_frame_ctrl
//
// Self-checking bench for can_rx_frame_ctrl. The bench plays the role of the
// bit sampler: it drives din for SOF detection and issues sample strobes
// with properly stuffed frame bits. Every destuffed bit it sends is queued
// as an expected value; a monitor pops and compares each bit_dvalid.
// ---------------------------------------------------------------------------
module tb_can_rx_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        din;
   logic        sample_bit;
   logic        sample_valid;
   logic        sample_en;
   logic        bit_dout;
   logic        bit_dvalid;
   logic [2:0]  field;
   logic [10:0] id;
   logic        rtr;
   logic [3:0]  dlc;
   logic        hdr_valid;
   logic        frame_done;
   logic        stuff_err;
   logic        form_err;

   can_rx_frame_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .din          (din),
      .sample_bit   (sample_bit),
      .sample_valid (sample_valid),
      .sample_en    (sample_en),
      .bit_dout     (bit_dout),
      .bit_dvalid   (bit_dvalid),
      .field        (field),
      .id           (id),
      .rtr          (rtr),
      .dlc          (dlc),
      .hdr_valid    (hdr_valid),
      .frame_done   (frame_done),
      .stuff_err    (stuff_err),
      .form_err     (form_err)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] id;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
      logic [14:0] crc;
      int          exp_bits;
      int          exp_after_hdr;
      logic        exp_data_field;
   } frame_t;

   frame_t vec [4];

   int total = 0;
   int bad   = 0;

   bit exp_q [$];
   bit exp_b;
   int f_bits, f_after, f_hdr, f_done, f_stuff, f_form;
   bit hdr_seen, saw_data;
   bit tx_last;
   int tx_run;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the register updates.
   always @(negedge clk) begin
      if (bit_dvalid) begin
         f_bits++;
         if (hdr_seen) f_after++;
         checkOutput("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checkOutput("bit_dout", {31'd0, bit_dout}, {31'd0, exp_b});
         end
      end
      if (hdr_valid) begin
         f_hdr++;
         hdr_seen = 1'b1;
      end
      if (field == 3'd3) saw_data = 1'b1;
      if (frame_done) begin
         f_done++;
         checkOutput("done_en_low", {31'd0, sample_en}, 32'd0);
      end
      if (stuff_err) f_stuff++;
      if (form_err)  f_form++;
   end

   task automatic clear_counts();
      f_bits = 0; f_after = 0; f_hdr = 0; f_done = 0; f_stuff = 0; f_form = 0;
      hdr_seen = 1'b0; saw_data = 1'b0;
      exp_q.delete();
   endtask

   // All tasks start and end on a falling edge.
   task automatic wait_idle(input int n);
      din = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic sof_edge(input logic expect_en);
      din = 1'b0;
      @(negedge clk);
      checkOutput("sof_en", {31'd0, sample_en}, {31'd0, expect_en});
      din = 1'b1;
   endtask

   task automatic send_bit(input logic b);
      sample_bit   = b;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic start_frame();
      send_bit(1'b0);
      tx_last = 1'b0;
      tx_run  = 1;
   endtask

   // Sends one frame bit, inserting a stuff bit first when the run is full.
   task automatic send_stuffed(input logic b, input bit push);
      if (tx_run == 5) begin
         send_bit(~tx_last);
         tx_last = ~tx_last;
         tx_run  = 1;
      end
      if (push) exp_q.push_back(b);
      send_bit(b);
      if (b == tx_last) tx_run++;
      else begin
         tx_run  = 1;
         tx_last = b;
      end
   endtask

   task automatic applyStimulus(input frame_t f);
      int nbytes;
      clear_counts();
      start_frame();
      for (int i = 10; i >= 0; i--) send_stuffed(f.id[i], 1'b1);
      send_stuffed(f.rtr, 1'b1);
      send_stuffed(1'b0, 1'b1);
      send_stuffed(1'b0, 1'b1);
      for (int i = 3; i >= 0; i--) send_stuffed(f.dlc[i], 1'b1);
      if (!f.rtr) begin
         nbytes = (f.dlc > 4'd8) ? 8 : int'(f.dlc);
         for (int i = 0; i < 8 * nbytes; i++) send_stuffed(f.data[63-i], 1'b1);
      end
      for (int i = 14; i >= 0; i--) send_stuffed(f.crc[i], 1'b1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      vec[0] = '{id:11'h123, rtr:1'b0, dlc:4'd1, data:64'hA500_0000_0000_0000,
                 crc:15'h1ABC, exp_bits:41, exp_after_hdr:23, exp_data_field:1'b1};
      vec[1] = '{id:11'h000, rtr:1'b0, dlc:4'd2, data:64'h00FF_0000_0000_0000,
                 crc:15'h0000, exp_bits:49, exp_after_hdr:31, exp_data_field:1'b1};
      vec[2] = '{id:11'h7F0, rtr:1'b0, dlc:4'd9, data:64'h0123_4567_89AB_CDEF,
                 crc:15'h7FFF, exp_bits:97, exp_after_hdr:79, exp_data_field:1'b1};
      vec[3] = '{id:11'h2AA, rtr:1'b1, dlc:4'd4, data:64'h0,
                 crc:15'h3333, exp_bits:33, exp_after_hdr:15, exp_data_field:1'b0};

      rst_n = 1'b0; din = 1'b1; sample_bit = 1'b0; sample_valid = 1'b0;
      clear_counts();
      repeat (3) @(negedge clk);
      checkOutput("rst_sample_en", {31'd0, sample_en}, 32'd0);
      checkOutput("rst_field", {29'd0, field}, 32'd0);
      checkOutput("rst_id_rtr_dlc", {16'd0, id, rtr, dlc}, 32'd0);
      checkOutput("rst_pulses", {27'd0, bit_dvalid, hdr_valid, frame_done, stuff_err, form_err}, 32'd0);
      rst_n = 1'b1;

      // Idle qualification: 10 bit times is not enough, 11 is.
      wait_idle(1000);
      sof_edge(1'b0);
      wait_idle(1100);
      sof_edge(1'b1);

      // Glitch: recessive first sample drops the enable silently.
      clear_counts();
      send_bit(1'b1);
      checkOutput("glitch_en", {31'd0, sample_en}, 32'd0);
      checkOutput("glitch_errs", f_stuff + f_form + f_bits, 32'd0);
      wait_idle(3);
      sof_edge(1'b1);
      send_bit(1'b1);
      checkOutput("glitch2_en", {31'd0, sample_en}, 32'd0);

      // Table-driven frames.
      for (int k = 0; k < 4; k++) begin
         wait_idle(1100);
         sof_edge(1'b1);
         applyStimulus(vec[k]);
         checkOutput("frm_bits", f_bits, vec[k].exp_bits);
         checkOutput("frm_after_hdr", f_after, vec[k].exp_after_hdr);
         checkOutput("frm_hdr", f_hdr, 32'd1);
         checkOutput("frm_done", f_done, 32'd1);
         checkOutput("frm_errs", f_stuff + f_form, 32'd0);
         checkOutput("frm_id", {21'd0, id}, {21'd0, vec[k].id});
         checkOutput("frm_rtr", {31'd0, rtr}, {31'd0, vec[k].rtr});
         checkOutput("frm_dlc", {28'd0, dlc}, {28'd0, vec[k].dlc});
         checkOutput("frm_data_field", {31'd0, saw_data}, {31'd0, vec[k].exp_data_field});
         checkOutput("frm_queue", exp_q.size(), 32'd0);
         checkOutput("frm_end_en", {31'd0, sample_en}, 32'd0);
         checkOutput("frm_end_field", {29'd0, field}, 32'd0);
      end

      // Stuff violation: SOF + 4 dominant ID bits, then a dominant stuff bit.
      wait_idle(1100);
      sof_edge(1'b1);
      clear_counts();
      start_frame();
      for (int i = 0; i < 4; i++) send_stuffed(1'b0, 1'b1);
      send_bit(1'b0);
      checkOutput("stuff_err_cnt", f_stuff, 32'd1);
      checkOutput("stuff_bits", f_bits, 32'd4);
      checkOutput("stuff_en", {31'd0, sample_en}, 32'd0);
      checkOutput("stuff_field", {29'd0, field}, 32'd0);
      wait_idle(20);
      sof_edge(1'b0);

      // IDE=1 is rejected with form_err and no header.
      wait_idle(1100);
      sof_edge(1'b1);
      clear_counts();
      start_frame();
      for (int i = 10; i >= 0; i--) send_stuffed(logic'((11'h155 >> i) & 11'h1), 1'b1);
      send_stuffed(1'b0, 1'b1);
      send_stuffed(1'b1, 1'b0);
      checkOutput("form_err_cnt", f_form, 32'd1);
      checkOutput("form_hdr", f_hdr, 32'd0);
      checkOutput("form_bits", f_bits, 32'd12);
      checkOutput("form_en", {31'd0, sample_en}, 32'd0);

      // Reset in the middle of the data field.
      wait_idle(1100);
      sof_edge(1'b1);
      clear_counts();
      start_frame();
      for (int i = 10; i >= 0; i--) send_stuffed(logic'((11'h5A5 >> i) & 11'h1), 1'b1);
      send_stuffed(1'b0, 1'b1);
      send_stuffed(1'b0, 1'b1);
      send_stuffed(1'b0, 1'b1);
      for (int i = 3; i >= 0; i--) send_stuffed(logic'((4'd2 >> i) & 4'h1), 1'b1);
      for (int i = 0; i < 3; i++) send_stuffed(1'b1, 1'b1);
      checkOutput("mid_field", {29'd0, field}, 32'd3);
      checkOutput("mid_id", {21'd0, id}, 32'h5A5);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_en", {31'd0, sample_en}, 32'd0);
      checkOutput("mid_rst_field", {29'd0, field}, 32'd0);
      checkOutput("mid_rst_id_rtr_dlc", {16'd0, id, rtr, dlc}, 32'd0);
      checkOutput("mid_rst_pulses", {27'd0, bit_dvalid, hdr_valid, frame_done, stuff_err, form_err}, 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      wait_idle(1000);
      sof_edge(1'b0);
      wait_idle(1100);
      sof_edge(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
